ibex_instr_mem_responder: RTL and testbench

Responder end of the core's instruction fetch interface (req/gnt/addr, then rvalid/rdata). Backed by a word-addressed instruction RAM. Grants requests subject to an outstanding-request limit and returns data in order after a fixed latency. Used as the instruction TCM / simulation memory sitting opposite the prefetch buffer; a sideband write port loads the program.

---
 rtl/ibex_instr_mem_responder.sv | 135 +++++++++++++
 tb/tb_ibex_instr_mem_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ibex_instr_mem_responder.sv
// Instruction-fetch responder: word RAM behind a req/gnt + rvalid/rdata port with fixed
// read latency and an outstanding-request limit. Define IMEM_GNT_STALL_EN for LFSR grant stalls.
module ibex_instr_mem_responder #(
  parameter int          MEM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        wr_en_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i,
  output logic        busy_o
);

  localparam int          AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int          PD    = (LATENCY > 1) ? LATENCY - 1 : 1;
  localparam int          PREV  = (LATENCY > 1) ? LATENCY - 2 : 0;
  localparam logic [2:0]  MAX_O = 3'(MAX_OUTSTANDING);
  localparam logic [31:0] WORDS = 32'(MEM_WORDS);

  logic [31:0] mem [MEM_WORDS];

  logic [31:0] rd_off, rd_widx, wr_off, wr_widx;
  logic        rd_in_range, wr_in_range;
  logic [31:0] rd_word;
  logic        stall, hs;
  logic [2:0]  outstanding;

  logic [LATENCY-1:0] vld_p;
  logic [31:0]        data_p [PD];
  logic               err_p  [PD];
  logic               vld_last_in, err_last_in;
  logic [31:0]        data_last_in;
  logic [31:0]        rdata_q;
  logic               err_q;

  assign rd_off      = instr_addr_i - BASE_ADDR;
  assign rd_widx     = rd_off >> 2;
  assign rd_in_range = (instr_addr_i >= BASE_ADDR) && (rd_widx < WORDS);
  assign wr_off      = wr_addr_i - BASE_ADDR;
  assign wr_widx     = wr_off >> 2;
  assign wr_in_range = (wr_addr_i >= BASE_ADDR) && (wr_widx < WORDS);

  // Out-of-range reads return zero data flagged as an error.
  assign rd_word = rd_in_range ? mem[rd_widx[AW-1:0]] : 32'h0;

`ifdef IMEM_GNT_STALL_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr <= 16'hACE1;
    else         lfsr <= {lfsr[14:0], lfsr_fb};
  end

  assign stall = lfsr[0] & lfsr[1];
`else
  assign stall = 1'b0;
`endif

  assign instr_gnt_o = instr_req_i & (outstanding < MAX_O) & ~stall;
  assign hs          = instr_req_i & instr_gnt_o;

  // Write and read share the edge; the nonblocking update makes a same-word read see old data.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && wr_in_range) mem[wr_widx[AW-1:0]] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding <= 3'd0;
    end else begin
      case ({hs, instr_rvalid_o})
        2'b10:   outstanding <= outstanding + 3'd1;
        2'b01:   outstanding <= outstanding - 3'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // ---- stage p0 .. p(LATENCY-1): valid shift, reset so a flush drops pending responses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= hs;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    data_p[0] <= rd_word;
    err_p[0]  <= ~rd_in_range;
    for (int i = 1; i < PD; i++) begin
      data_p[i] <= data_p[i-1];
      err_p[i]  <= err_p[i-1];
    end
  end

  assign vld_last_in  = (LATENCY == 1) ? hs           : vld_p[PREV];
  assign data_last_in = (LATENCY == 1) ? rd_word      : data_p[PREV];
  assign err_last_in  = (LATENCY == 1) ? ~rd_in_range : err_p[PREV];

  // ---- output stage: captured only on a valid entry so data/err hold between responses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (vld_last_in) begin
      rdata_q <= data_last_in;
      err_q   <= err_last_in;
    end
  end

  assign instr_rvalid_o = vld_p[LATENCY-1];
  assign instr_rdata_o  = rdata_q;
  assign instr_err_o    = err_q;
  assign busy_o         = (outstanding != 3'd0);

`ifndef SYNTHESIS
  outstanding_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    outstanding <= MAX_O);
`endif

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Bench: vector table + response scoreboard on a LATENCY=1 instance, hand sequences on a
// LATENCY=3 instance for outstanding-limit and mid-flight reset behaviour.
module tb_ibex_instr_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] wr_addr, wr_data;

  logic        req1, gnt1, rvalid1, err1, busy1;
  logic [31:0] addr1, rdata1;
  logic        req3, gnt3, rvalid3, err3, busy3;
  logic [31:0] addr3, rdata3;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ibex_instr_mem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1), .MAX_OUTSTANDING(2)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req1), .instr_addr_i(addr1), .instr_gnt_o(gnt1),
    .instr_rvalid_o(rvalid1), .instr_rdata_o(rdata1), .instr_err_o(err1),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .busy_o(busy1));

  ibex_instr_mem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(3), .MAX_OUTSTANDING(2)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req3), .instr_addr_i(addr3), .instr_gnt_o(gnt3),
    .instr_rvalid_o(rvalid3), .instr_rdata_o(rdata3), .instr_err_o(err3),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .busy_o(busy3));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference memory and response scoreboard for u_dut1
  typedef struct { logic [31:0] data; logic err; int due; } resp_t;
  resp_t       sbq[$];
  logic [31:0] model [1024];

  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid1) begin
        if (sbq.size() == 0) begin
          check("unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          resp_t r;
          r = sbq.pop_front();
          check("resp_data", rdata1, r.data);
          check("resp_err", {31'd0, err1}, {31'd0, r.err});
          check("resp_cycle", cyc, r.due);
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        check("missing_rvalid", 32'd0, 32'd1);
        void'(sbq.pop_front());
      end
      if (req1 && gnt1) begin
        resp_t r;
        r.err  = (addr1 >= 32'h1000);
        r.data = r.err ? 32'h0 : model[addr1[11:2]];
        r.due  = cyc + 1;
        sbq.push_back(r);
      end
      if (wr_en && wr_addr < 32'h1000) model[wr_addr[11:2]] = wr_data;
    end
  end

  typedef struct {
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        req;
    logic [31:0] addr;
    logic        exp_gnt;
  } vec_t;

  function automatic vec_t mk(logic we, logic [31:0] wa, logic [31:0] wd,
                              logic rq, logic [31:0] ra, logic eg);
    vec_t v;
    v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.req = rq; v.addr = ra; v.exp_gnt = eg;
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t        vecs[$];
    logic [9:0]  eg3, ev3, eb3;

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    req1 = 1'b0; addr1 = '0; req3 = 1'b0; addr3 = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", {31'd0, gnt1}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid1}, 32'd0);
    check("rst_rdata", rdata1, 32'd0);
    check("rst_err", {31'd0, err1}, 32'd0);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_rdata3", rdata3, 32'd0);
    check("rst_busy3", {31'd0, busy3}, 32'd0);
    next_cycle();
    rst_n = 1'b1;

    vecs.push_back(mk(1, 32'h0,   32'h0000_0013, 0, 32'h0,    0));
    vecs.push_back(mk(0, 32'h0,   32'h0,         1, 32'h0,    1));
    vecs.push_back(mk(0, 32'h0,   32'h0,         0, 32'h0,    0));
    vecs.push_back(mk(1, 32'h0,   32'h0000_00A0, 0, 32'h0,    0));
    vecs.push_back(mk(1, 32'h4,   32'h0000_00A1, 0, 32'h0,    0));
    vecs.push_back(mk(1, 32'h8,   32'h0000_00A2, 0, 32'h0,    0));
    vecs.push_back(mk(1, 32'hC,   32'h0000_00A3, 0, 32'h0,    0));
    vecs.push_back(mk(1, 32'hFFC, 32'h0000_0055, 0, 32'h0,    0));
    vecs.push_back(mk(0, 32'h0,   32'h0,         1, 32'h0,    1));
    vecs.push_back(mk(0, 32'h0,   32'h0,         1, 32'h4,    1));
    vecs.push_back(mk(0, 32'h0,   32'h0,         1, 32'h8,    1));
    vecs.push_back(mk(0, 32'h0,   32'h0,         1, 32'hC,    1));
    vecs.push_back(mk(0, 32'h0,   32'h0,         0, 32'h0,    0));
    vecs.push_back(mk(0, 32'h0,   32'h0,         1, 32'hFFC,  1));
    vecs.push_back(mk(0, 32'h0,   32'h0,         1, 32'h1000, 1));
    vecs.push_back(mk(0, 32'h0,   32'h0,         0, 32'h0,    0));
    vecs.push_back(mk(1, 32'h10,  32'h1111_1111, 0, 32'h0,    0));
    vecs.push_back(mk(1, 32'h10,  32'hDEAD_BEEF, 1, 32'h10,   1));
    vecs.push_back(mk(1, 32'h1000, 32'h1234_5678, 1, 32'h10,  1));
    vecs.push_back(mk(0, 32'h0,   32'h0,         0, 32'h0,    0));
    vecs.push_back(mk(0, 32'h0,   32'h0,         0, 32'h0,    0));

    foreach (vecs[i]) begin
      wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      req1 = vecs[i].req; addr1 = vecs[i].addr;
      @(negedge clk);
      check($sformatf("vec%0d_gnt", i), {31'd0, gnt1}, {31'd0, vecs[i].exp_gnt});
      next_cycle();
    end
    wr_en = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check("hold_rvalid", {31'd0, rvalid1}, 32'd0);
    check("hold_rdata", rdata1, 32'hDEAD_BEEF);
    check("hold_busy", {31'd0, busy1}, 32'd0);
    next_cycle();

    // LATENCY=3, MAX_OUTSTANDING=2: req held for 6 cycles then dropped
    eg3 = 10'b0000110011;
    ev3 = 10'b0110011000;
    eb3 = 10'b0111111110;
    for (int k = 0; k < 10; k++) begin
      req3 = (k < 6); addr3 = 32'h0;
      @(negedge clk);
      check($sformatf("lim_gnt_c%0d", k), {31'd0, gnt3}, {31'd0, eg3[k]});
      check($sformatf("lim_rvalid_c%0d", k), {31'd0, rvalid3}, {31'd0, ev3[k]});
      check($sformatf("lim_busy_c%0d", k), {31'd0, busy3}, {31'd0, eb3[k]});
      if (ev3[k]) check($sformatf("lim_rdata_c%0d", k), rdata3, 32'h0000_00A0);
      next_cycle();
    end
    req3 = 1'b0;

    // Reset one cycle after a grant: the pending response must never appear
    req3 = 1'b1; addr3 = 32'h4;
    @(negedge clk);
    check("flush_gnt", {31'd0, gnt3}, 32'd1);
    next_cycle();
    req3 = 1'b0; rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("flush_rvalid_c%0d", k), {31'd0, rvalid3}, 32'd0);
      check($sformatf("flush_busy_c%0d", k), {31'd0, busy3}, 32'd0);
      next_cycle();
    end
    req3 = 1'b1; addr3 = 32'h8;
    @(negedge clk);
    check("post_flush_gnt", {31'd0, gnt3}, 32'd1);
    next_cycle();
    req3 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("post_flush_rvalid_c%0d", k), {31'd0, rvalid3}, {31'd0, k == 3});
      if (k == 3) begin
        check("post_flush_rdata", rdata3, 32'h0000_00A2);
        check("post_flush_err", {31'd0, err3}, 32'd0);
      end
      next_cycle();
    end

    @(negedge clk);
    check("scoreboard_drained", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
